bus_init_sequencer: RTL and testbench



---
 rtl/bus_init_sequencer.sv | 126 ++++++++++++
 tb/tb_bus_init_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_init_sequencer.sv
// Power-up and initialisation sequencer for the CAN buses of the MOPSHUB top.
// Walks buses 0..nb: power enable, settle, bus reset, optional oscillator trim with timeout.
module bus_init_sequencer #(
    parameter int          N_BUS_MAX    = 16,
    parameter logic [15:0] SETTLE_CYC   = 16'd400,
    parameter logic [19:0] TRIM_TIMEOUT = 20'd40000
) (
    input  logic                 clk_40_m,
    input  logic                 rst,
    input  logic                 start_init,
    input  logic [4:0]           n_buses,
    input  logic                 osc_auto_trim,
    input  logic                 end_trim_bus,
    output logic                 power_bus_en,
    output logic [4:0]           power_bus_cnt,
    output logic                 rst_bus,
    output logic                 start_trim_ack,
    output logic [N_BUS_MAX-1:0] trim_fail,
    output logic                 end_power_init,
    output logic                 end_init,
    output logic                 busy
);

    localparam int         IDX_W    = $clog2(N_BUS_MAX);
    localparam logic [4:0] LAST_BUS = 5'(N_BUS_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, PWR_ON, SETTLE, BUS_RST, TRIM_REQ, TRIM_WAIT, NEXT, DONE
    } state_t;

    state_t      state, next_state;
    logic [4:0]  nb;
    logic        trim_en;
    logic [19:0] tmr;
    logic        tmr_zero;
    logic        last_bus;
    logic        trim_timeout;

    logic power_bus_en_d, rst_bus_d, start_trim_ack_d, end_power_init_d, end_init_d, busy_d;

    assign tmr_zero     = (tmr == 20'd0);
    assign last_bus     = (power_bus_cnt == nb);
    assign trim_timeout = (state == TRIM_WAIT) && !end_trim_bus && tmr_zero;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_40_m) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_init) next_state = PWR_ON;
            PWR_ON:    next_state = SETTLE;
            SETTLE:    if (tmr_zero) next_state = BUS_RST;
            BUS_RST:   next_state = trim_en ? TRIM_REQ : NEXT;
            TRIM_REQ:  next_state = TRIM_WAIT;
            TRIM_WAIT: if (end_trim_bus || tmr_zero) next_state = NEXT;
            NEXT:      next_state = last_bus ? DONE : PWR_ON;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so each pulse lines up with its state.
    always_comb begin
        power_bus_en_d   = (next_state == PWR_ON);
        rst_bus_d        = (next_state == BUS_RST);
        start_trim_ack_d = (next_state == TRIM_REQ);
        end_power_init_d = (next_state == NEXT) && last_bus;
        end_init_d       = (next_state == DONE);
        busy_d           = (next_state != IDLE);
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            power_bus_en   <= 1'b0;
            rst_bus        <= 1'b0;
            start_trim_ack <= 1'b0;
            end_power_init <= 1'b0;
            end_init       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            power_bus_en   <= power_bus_en_d;
            rst_bus        <= rst_bus_d;
            start_trim_ack <= start_trim_ack_d;
            end_power_init <= end_power_init_d;
            end_init       <= end_init_d;
            busy           <= busy_d;
        end
    end

    // One down-counter serves both the settle delay and the trim timeout.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            nb            <= 5'd0;
            trim_en       <= 1'b0;
            power_bus_cnt <= 5'd0;
            trim_fail     <= '0;
            tmr           <= 20'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_init) begin
                        nb            <= (n_buses > LAST_BUS) ? LAST_BUS : n_buses;
                        trim_en       <= osc_auto_trim;
                        power_bus_cnt <= 5'd0;
                        trim_fail     <= '0;
                    end
                end
                PWR_ON:   tmr <= 20'(SETTLE_CYC) - 20'd1;
                TRIM_REQ: tmr <= TRIM_TIMEOUT - 20'd1;
                SETTLE:   if (!tmr_zero) tmr <= tmr - 20'd1;
                TRIM_WAIT: begin
                    if (!tmr_zero) tmr <= tmr - 20'd1;
                    if (trim_timeout) trim_fail[power_bus_cnt[IDX_W-1:0]] <= 1'b1;
                end
                NEXT:     if (!last_bus) power_bus_cnt <= power_bus_cnt + 5'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Scoreboard bench for bus_init_sequencer: expected pulse events (kind, bus index, spacing)
// are queued when a sequence is started and popped as the DUT produces them.
module tb_bus_init_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    logic        clk_40_m = 1'b0;
    logic        rst;
    logic        start_init;
    logic [4:0]  n_buses;
    logic        osc_auto_trim;
    logic        end_trim_bus = 1'b0;
    logic        power_bus_en;
    logic [4:0]  power_bus_cnt;
    logic        rst_bus;
    logic        start_trim_ack;
    logic [15:0] trim_fail;
    logic        end_power_init;
    logic        end_init;
    logic        busy;

    bus_init_sequencer #(
        .N_BUS_MAX   (16),
        .SETTLE_CYC  (16'(SETTLE)),
        .TRIM_TIMEOUT(20'(TIMEOUT))
    ) dut (
        .clk_40_m      (clk_40_m),
        .rst           (rst),
        .start_init    (start_init),
        .n_buses       (n_buses),
        .osc_auto_trim (osc_auto_trim),
        .end_trim_bus  (end_trim_bus),
        .power_bus_en  (power_bus_en),
        .power_bus_cnt (power_bus_cnt),
        .rst_bus       (rst_bus),
        .start_trim_ack(start_trim_ack),
        .trim_fail     (trim_fail),
        .end_power_init(end_power_init),
        .end_init      (end_init),
        .busy          (busy)
    );

    always #5 clk_40_m = ~clk_40_m;

    typedef enum int {EV_PWR, EV_RST, EV_ACK, EV_EPI, EV_EI} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cnt;
        int       dly;   // cycles since previous event, -1 = not checked
    } ev_t;

    ev_t exp_q[$];
    int  resp_dly[16];   // trim responder delay per bus, 0 = silent
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  last_evt = 0;
    int  trim_timer = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int resp_eff(input int b);
        return (resp_dly[b] == 0) ? TIMEOUT : resp_dly[b];
    endfunction

    task automatic plan(input int nreq, input bit trim);
        int nb;
        int gap;
        nb  = (nreq > 15) ? 15 : nreq;
        gap = -1;
        for (int b = 0; b <= nb; b++) begin
            exp_q.push_back('{EV_PWR, b, gap});
            exp_q.push_back('{EV_RST, b, SETTLE + 1});
            if (trim) exp_q.push_back('{EV_ACK, b, 1});
            gap = trim ? resp_eff(b) + 2 : 2;
        end
        exp_q.push_back('{EV_EPI, nb, trim ? resp_eff(nb) + 1 : 1});
        exp_q.push_back('{EV_EI, nb, 1});
    endtask

    task automatic pulse_start(input int nreq, input bit trim);
        n_buses       = 5'(nreq);
        osc_auto_trim = trim;
        start_init    = 1'b1;
        @(negedge clk_40_m);
        start_init    = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_40_m);
        check("sequence_in_time", exp_q.size(), 0);
        repeat (3) @(negedge clk_40_m);
        check("busy_idle", busy, 0);
    endtask

    always @(posedge clk_40_m) cyc++;

    // Trim engine model: answers each start_trim_ack after resp_dly cycles.
    always @(negedge clk_40_m) begin
        if (!rst) begin
            trim_timer   = 0;
            end_trim_bus = 1'b0;
        end else begin
            end_trim_bus = 1'b0;
            if (trim_timer > 0) begin
                trim_timer--;
                if (trim_timer == 0) end_trim_bus = 1'b1;
            end
            if (start_trim_ack && resp_dly[power_bus_cnt[3:0]] != 0)
                trim_timer = resp_dly[power_bus_cnt[3:0]];
        end
    end

    // Event monitor: pops the scoreboard on every output pulse.
    always @(negedge clk_40_m) begin : monitor
        int       nhot;
        ev_kind_t kind;
        ev_t      e;
        if (rst) begin
            nhot = int'(power_bus_en) + int'(rst_bus) + int'(start_trim_ack)
                 + int'(end_power_init) + int'(end_init);
            if (nhot != 0) begin
                kind = power_bus_en   ? EV_PWR :
                       rst_bus        ? EV_RST :
                       start_trim_ack ? EV_ACK :
                       end_power_init ? EV_EPI : EV_EI;
                check("single_pulse", nhot, 1);
                check("event_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("event_kind", int'(kind), int'(e.kind));
                    check("event_bus", power_bus_cnt, e.cnt);
                    if (e.dly >= 0) check("event_spacing", cyc - last_evt, e.dly);
                end
                last_evt = cyc;
            end
        end
    end

    initial begin
        rst           = 1'b0;
        start_init    = 1'b0;
        n_buses       = 5'd0;
        osc_auto_trim = 1'b0;
        for (int i = 0; i < 16; i++) resp_dly[i] = 10;
        repeat (3) @(negedge clk_40_m);
        check("rst_power_bus_en", power_bus_en, 0);
        check("rst_power_bus_cnt", power_bus_cnt, 0);
        check("rst_rst_bus", rst_bus, 0);
        check("rst_start_trim_ack", start_trim_ack, 0);
        check("rst_trim_fail", trim_fail, 0);
        check("rst_end_power_init", end_power_init, 0);
        check("rst_end_init", end_init, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk_40_m);

        // 1: four buses, no trim, 7-cycle bus period
        plan(3, 0);
        pulse_start(3, 0);
        wait_done(200);
        check("t1_trim_fail", trim_fail, 16'h0000);
        check("t1_cnt_hold", power_bus_cnt, 3);

        // 2: all 16 buses with trim answered after 10 cycles
        plan(15, 1);
        pulse_start(15, 1);
        wait_done(2000);
        check("t2_trim_fail", trim_fail, 16'h0000);

        // 3: bus 2 trim silent -> timeout flag
        resp_dly[2] = 0;
        plan(4, 1);
        pulse_start(4, 1);
        wait_done(1000);
        check("t3_trim_fail", trim_fail, 16'h0004);

        // 4: answer lands in the expiry cycle for bus 1; flags cleared by the new start
        resp_dly[2] = 10;
        resp_dly[1] = TIMEOUT;
        plan(2, 1);
        pulse_start(2, 1);
        wait_done(1000);
        check("t4_trim_fail", trim_fail, 16'h0000);

        // 5: reset during settle of bus 5 after bus 0 timed out
        resp_dly[1] = 10;
        resp_dly[0] = 0;
        plan(7, 1);
        pulse_start(7, 1);
        begin
            int i;
            for (i = 0; i < 1000 && !(power_bus_en && power_bus_cnt == 5'd5); i++)
                @(negedge clk_40_m);
            check("t5_reached_bus5", i < 1000, 1);
        end
        repeat (2) @(negedge clk_40_m);
        check("t5_flag_before_rst", trim_fail, 16'h0001);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk_40_m);
        check("t5_power_bus_en", power_bus_en, 0);
        check("t5_cnt", power_bus_cnt, 0);
        check("t5_rst_bus", rst_bus, 0);
        check("t5_ack", start_trim_ack, 0);
        check("t5_trim_fail", trim_fail, 0);
        check("t5_end_power_init", end_power_init, 0);
        check("t5_end_init", end_init, 0);
        check("t5_busy", busy, 0);
        rst = 1'b1;
        resp_dly[0] = 10;
        repeat (2) @(negedge clk_40_m);
        plan(1, 0);
        pulse_start(1, 0);
        wait_done(200);
        check("t5_restart_trim_fail", trim_fail, 16'h0000);

        // 6: n_buses clamp, restart and input changes while busy are ignored
        plan(31, 0);
        pulse_start(31, 0);
        repeat (20) @(negedge clk_40_m);
        start_init    = 1'b1;
        n_buses       = 5'd2;
        osc_auto_trim = 1'b1;
        @(negedge clk_40_m);
        start_init    = 1'b0;
        wait_done(400);
        repeat (20) @(negedge clk_40_m);
        check("t6_no_extra_events", exp_q.size(), 0);
        check("t6_cnt_clamped", power_bus_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
